// File: rtl/sap1_control_sequencer.sv
// SAP-1 microcode sequencer: step counter plus opcode decode producing the per-cycle control word.
// Step state advances on clk_en and freezes on HLT until reset.
//
// step | meaning
// 0    | fetch: PC -> MAR
// 1    | fetch: RAM -> IR, PC++
// 2    | decode/execute 1 (operand address, LDI, jumps, OUT, HLT)
// 3    | execute 2 (memory read/write)
// 4    | execute 3 (ALU writeback)
// 5..  | idle padding when NUM_STEPS > 5
module sap1_control_sequencer #(
   parameter int NUM_STEPS  = 5,
   parameter int STEP_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clk_en,
   input  logic [3:0]            i_opcode,
   input  logic                  i_carry,
   input  logic                  i_zero,
   output logic [STEP_WIDTH-1:0] o_step,
   output logic                  o_pc_out,
   output logic                  o_pc_count_en,
   output logic                  o_pc_load_en,
   output logic                  o_halt,
   output logic                  o_mar_load,
   output logic                  o_ram_out,
   output logic                  o_ram_load,
   output logic                  o_ir_load,
   output logic                  o_ir_out,
   output logic                  o_a_load,
   output logic                  o_a_out,
   output logic                  o_b_load,
   output logic                  o_alu_out,
   output logic                  o_alu_sub,
   output logic                  o_flags_load,
   output logic                  o_out_load
);

   localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
                          OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
                          OP_OUT = 4'hE, OP_HLT = 4'hF;
   localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(NUM_STEPS - 1);
   localparam logic [STEP_WIDTH-1:0] STEP_0 = STEP_WIDTH'(0), STEP_1 = STEP_WIDTH'(1),
                                     STEP_2 = STEP_WIDTH'(2), STEP_3 = STEP_WIDTH'(3),
                                     STEP_4 = STEP_WIDTH'(4);

   logic [STEP_WIDTH-1:0] step;
   logic                  halted;
   logic                  hlt_decode;
   logic                  halt_now;

   assign hlt_decode = (step == STEP_2) && (i_opcode == OP_HLT);
   assign halt_now   = halted || hlt_decode;

   // The latching edge of HLT must not advance the step, so o_step stays at 2.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step   <= '0;
         halted <= 1'b0;
      end else if (clk_en && !halt_now) begin
         step <= (step == LAST_STEP) ? '0 : step + STEP_WIDTH'(1);
      end else if (clk_en && hlt_decode) begin
         halted <= 1'b1;
      end
   end

   assign o_step = step;

   always_comb begin
      o_pc_out      = 1'b0;
      o_pc_count_en = 1'b0;
      o_pc_load_en  = 1'b0;
      o_halt        = halt_now;
      o_mar_load    = 1'b0;
      o_ram_out     = 1'b0;
      o_ram_load    = 1'b0;
      o_ir_load     = 1'b0;
      o_ir_out      = 1'b0;
      o_a_load      = 1'b0;
      o_a_out       = 1'b0;
      o_b_load      = 1'b0;
      o_alu_out     = 1'b0;
      o_alu_sub     = 1'b0;
      o_flags_load  = 1'b0;
      o_out_load    = 1'b0;
      if (!halted) begin
         case (step)
            STEP_0: begin
               o_pc_out   = 1'b1;
               o_mar_load = 1'b1;
            end
            STEP_1: begin
               o_ram_out     = 1'b1;
               o_ir_load     = 1'b1;
               o_pc_count_en = 1'b1;
            end
            STEP_2: begin
               case (i_opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     o_ir_out   = 1'b1;
                     o_mar_load = 1'b1;
                  end
                  OP_LDI: begin
                     o_ir_out = 1'b1;
                     o_a_load = 1'b1;
                  end
                  OP_JMP: begin
                     o_ir_out     = 1'b1;
                     o_pc_load_en = 1'b1;
                  end
                  OP_JC: begin
                     o_ir_out     = 1'b1;
                     o_pc_load_en = i_carry;
                  end
                  OP_JZ: begin
                     o_ir_out     = 1'b1;
                     o_pc_load_en = i_zero;
                  end
                  OP_OUT: begin
                     o_a_out    = 1'b1;
                     o_out_load = 1'b1;
                  end
                  default: ;
               endcase
            end
            STEP_3: begin
               case (i_opcode)
                  OP_LDA: begin
                     o_ram_out = 1'b1;
                     o_a_load  = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     o_ram_out = 1'b1;
                     o_b_load  = 1'b1;
                  end
                  OP_STA: begin
                     o_a_out    = 1'b1;
                     o_ram_load = 1'b1;
                  end
                  default: ;
               endcase
            end
            STEP_4: begin
               if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                  o_alu_out    = 1'b1;
                  o_a_load     = 1'b1;
                  o_flags_load = 1'b1;
                  o_alu_sub    = (i_opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
